// File: rtl/alu_muldiv.sv
// Registered RISC-V ALU with iterative unsigned multiply/divide behind a start/ready/done handshake.
// Single-cycle ops finish one clock after acceptance; MUL/MULHU/DIVU/REMU take WIDTH clocks.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel_q, sel_d;
    // hreg: product high half (MUL) or partial remainder (DIV).
    logic [WIDTH-1:0] hreg_q, hreg_d;
    // sreg: multiplier shifting out / product low half in (MUL), dividend out / quotient in (DIV).
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             lt_s;
    logic             lt_u;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    logic             is_mul;
    logic             is_div;

    assign shamt = SrcB[SHW-1:0];
    assign lt_s  = $signed(SrcA) < $signed(SrcB);
    assign lt_u  = SrcA < SrcB;

    always_comb begin
        alu_res = SrcA;
        case (ALUControl)
            4'b0000: alu_res = SrcA + SrcB;
            4'b0001: alu_res = SrcA - SrcB;
            4'b0010: alu_res = SrcA & SrcB;
            4'b0011: alu_res = SrcA | SrcB;
            4'b0100: alu_res = SrcA ^ SrcB;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            4'b0111: alu_res = SrcA << shamt;
            4'b1000: alu_res = SrcA >> shamt;
            4'b1001: alu_res = $signed(SrcA) >>> shamt;
            default: alu_res = SrcA;
        endcase
    end

    // Shift-add step: the sum's LSB becomes the next product bit entering sreg from the top.
    assign mul_sum     = {1'b0, hreg_q} + {1'b0, (sreg_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign mul_lo_next = {mul_sum[0], sreg_q[WIDTH-1:1]};

    // Restoring step; the partial remainder stays below the divisor, so WIDTH bits suffice.
    assign div_shift    = {hreg_q, sreg_q[WIDTH-1]};
    assign div_ge       = div_shift >= {1'b0, opb_q};
    assign div_diff     = div_shift[WIDTH-1:0] - opb_q;
    assign div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_quo_next = {sreg_q[WIDTH-2:0], div_ge};

    assign is_mul = (ALUControl == 4'b1010) || (ALUControl == 4'b1011);
    assign is_div = (ALUControl == 4'b1100) || (ALUControl == 4'b1101);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        hreg_d  = hreg_q;
        sreg_d  = sreg_q;
        opb_d   = opb_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = CW'(WIDTH);
                        sel_d   = ALUControl[0];
                        hreg_d  = '0;
                        sreg_d  = SrcB;
                        opb_d   = SrcA;
                    end else if (is_div) begin
                        if (SrcB == '0) begin
                            res_d  = ALUControl[0] ? SrcA : {WIDTH{1'b1}};
                            done_d = 1'b1;
                        end else begin
                            state_d = DIV;
                            cnt_d   = CW'(WIDTH);
                            sel_d   = ALUControl[0];
                            hreg_d  = '0;
                            sreg_d  = SrcA;
                            opb_d   = SrcB;
                        end
                    end else begin
                        res_d  = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                hreg_d = mul_sum[WIDTH:1];
                sreg_d = mul_lo_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = sel_q ? mul_sum[WIDTH:1] : mul_lo_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV: begin
                hreg_d = div_rem_next;
                sreg_d = div_quo_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = sel_q ? div_rem_next : div_quo_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            hreg_q  <= '0;
            sreg_q  <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            hreg_q  <= hreg_d;
            sreg_q  <= sreg_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected result and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic [3:0]    ALUControl;
    logic          ready;
    logic          done;
    logic [W-1:0]  ALUResult;
    logic          Zero;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUControl(ALUControl),
        .ready     (ready),
        .done      (done),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rst_chk = 1'b0;
    bit   end_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sole checker process.
    always @(negedge clk) begin
        exp_t e;
        if (rst_chk) begin
            checks++;
            if (ready !== 1'b1 || done !== 1'b0 || ALUResult !== '0 || Zero !== 1'b1) begin
                errors++;
                $display("FAIL reset_state: ready=%b done=%b res=%h zero=%b, need 1 0 0 1",
                         ready, done, ALUResult, Zero);
            end
        end
        if (end_chk) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL missing_done: %0d results outstanding, need 0", sb.size());
            end
        end
        if (rst_n && sb.size() > 0 && cyc < sb[0].cyc) begin
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready(%s): cyc=%0d ready=%b, need 0", sb[0].name, cyc, ready);
            end
        end
        if (rst_n && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: cyc=%0d res=%h, need no done", cyc, ALUResult);
            end else begin
                e = sb.pop_front();
                if (ALUResult !== e.res) begin
                    errors++;
                    $display("FAIL result(%s): got %h, need %h", e.name, ALUResult, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency(%s): done at cyc %0d, need %0d", e.name, cyc, e.cyc);
                end
                checks++;
                if (Zero !== (e.res == '0)) begin
                    errors++;
                    $display("FAIL zero(%s): got %b, need %b", e.name, Zero, (e.res == '0));
                end
            end
        end
    end

    // Drives at posedge+1; leaves start low so a following issue still lands back-to-back.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input bit track,
                         input string nm);
        int n;
        exp_t e;
        n = 0;
        while (ready !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL ready_timeout(%s): ready stuck low for %0d cycles", nm, n);
                $fatal(1, "ready timeout");
            end
        end
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        #1;
        if (track) begin
            e.res  = exp;
            e.cyc  = cyc + lat;
            e.name = nm;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    // Scrambles operands while busy; optionally pokes start once (must be ignored).
    task automatic wait_busy(input int n, input int poke_at);
        for (int i = 0; i < n; i++) begin
            SrcA  = $urandom;
            SrcB  = $urandom;
            start = (i == poke_at);
            if (i == poke_at) ALUControl = 4'b0000;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rst_chk = 1'b1;
        @(negedge clk);
        #1;
        rst_chk = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops.
        issue(4'b0001, 32'd5,          32'd7,          32'hFFFF_FFFE, 0, 1'b1, "sub");
        issue(4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1,         0, 1'b1, "slt");
        issue(4'b1001, 32'h8000_0000,  32'd4,          32'hF800_0000, 0, 1'b1, "sra");
        issue(4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,         0, 1'b1, "add_wrap");
        issue(4'b0010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000, 0, 1'b1, "and");
        issue(4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0, 0, 1'b1, "or");
        issue(4'b0100, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'hF0F0_F0F0, 0, 1'b1, "xor");
        issue(4'b0110, 32'hFFFF_FFFF,  32'd1,          32'd0,         0, 1'b1, "sltu");
        issue(4'b0101, 32'd1,          32'hFFFF_FFFF,  32'd0,         0, 1'b1, "slt_neg");
        issue(4'b0111, 32'd1,          32'd31,         32'h8000_0000, 0, 1'b1, "sll31");
        issue(4'b0111, 32'd1,          32'h0000_0021,  32'd2,         0, 1'b1, "sll_mask");
        issue(4'b1000, 32'h8000_0000,  32'd4,          32'h0800_0000, 0, 1'b1, "srl");
        issue(4'b1110, 32'hDEAD_BEEF,  32'h1234_5678,  32'hDEAD_BEEF, 0, 1'b1, "pass");

        // Multiply.
        issue(4'b1010, 32'h0001_0000,  32'h0001_0000,  32'd0,         W, 1'b1, "mul");
        wait_busy(W, -1);
        issue(4'b1011, 32'h0001_0000,  32'h0001_0000,  32'd1,         W, 1'b1, "mulhu");
        issue(4'b1010, 32'd7,          32'd6,          32'd42,        W, 1'b1, "mul_small");
        issue(4'b1011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, W, 1'b1, "mulhu_max");
        issue(4'b1010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         W, 1'b1, "mul_max");

        // Divide.
        issue(4'b1100, 32'd100,        32'd7,          32'd14,        W, 1'b1, "divu");
        issue(4'b1101, 32'd100,        32'd7,          32'd2,         W, 1'b1, "remu");
        issue(4'b1100, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, W, 1'b1, "divu_by1");
        issue(4'b1101, 32'hFFFF_FFFF,  32'd10,         32'd5,         W, 1'b1, "remu_max");
        issue(4'b1100, 32'd5,          32'd7,          32'd0,         W, 1'b1, "divu_small");

        // Divide by zero completes in one cycle.
        issue(4'b1100, 32'd42,         32'd0,          32'hFFFF_FFFF, 0, 1'b1, "divu_zero");
        issue(4'b1101, 32'd42,         32'd0,          32'd42,        0, 1'b1, "remu_zero");

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(4'b1100, 32'd100,        32'd7,          32'd14,        W, 1'b1, "divu_poked");
        wait_busy(W, 5);
        issue(4'b0000, 32'd3,          32'd4,          32'd7,         0, 1'b1, "add_in_done");

        // Reset mid-MUL: state cleared and no done afterwards.
        issue(4'b0000, 32'd2,          32'd3,          32'd5,         0, 1'b1, "add_pre_rst");
        issue(4'b1010, 32'h0000_1234,  32'h0000_5678,  32'd0,         W, 1'b0, "mul_aborted");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rst_chk = 1'b1;
        @(negedge clk);
        #1;
        rst_chk = 1'b0;
        repeat (2 * W) @(posedge clk);
        #1;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        end_chk = 1'b0;
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered ALU for the RISC-V core that extends the single-cycle integer ALU with XOR, shifts, unsigned compare, and iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU). It sits in the execute stage behind a start/ready/done handshake, so the control unit can stall on multi-cycle operations. Single-cycle operations complete one clock after acceptance. Multiply and divide use a shift-add / restoring-divide datapath of WIDTH iterations.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH) (derived, not overridable): shift-amount width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- start  in  1  request; accepted on a rising edge where start=1 and ready=1.
- SrcA  in  WIDTH  operand A; sampled only at acceptance.
- SrcB  in  WIDTH  operand B; sampled only at acceptance.
- ALUControl  in  4  operation select; sampled only at acceptance.
- ready  out  1  high when a new request can be accepted.
- done  out  1  one-cycle pulse: ALUResult is valid for the last accepted request.
- ALUResult  out  WIDTH  registered result; holds until the next completion.
- Zero  out  1  high when ALUResult == 0 (combinational from the result register).

## Operation
- ALUControl encodings:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT (signed); 0110 SLTU.
  - 0111 SLL; 1000 SRL; 1001 SRA. Shift amount = SrcB[SHW-1:0].
  - 1010 MUL (low WIDTH bits of the product); 1011 MULHU (high WIDTH bits of the unsigned product).
  - 1100 DIVU; 1101 REMU.
  - 1110, 1111: pass SrcA (single-cycle).
- All arithmetic is modulo 2^WIDTH. SLT/SLTU produce zero-extended 0 or 1.
- States:
  - IDLE: ready=1.
  - MUL: ready=0.
  - DIV: ready=0.
- Transitions from IDLE on acceptance:
  - Single-cycle op: compute, register the result, pulse done; stay in IDLE.
  - MUL/MULHU: latch operands, clear the 2·WIDTH accumulator, set the iteration counter to WIDTH; go to MUL.
  - DIVU/REMU with SrcB ≠ 0: latch operands, clear the remainder; go to DIV.
  - DIVU/REMU with SrcB = 0: complete immediately. DIVU returns all-ones; REMU returns SrcA. Stay in IDLE.
- MUL: each cycle add the multiplicand when the current multiplier LSB = 1, then shift; decrement the counter. At counter = 1, the last iteration registers the selected half, pulses done and returns to IDLE.
- DIV: restoring algorithm, one quotient bit per cycle, WIDTH iterations. The final iteration registers the quotient (DIVU) or remainder (REMU), pulses done and returns to IDLE.
- start while ready=0 is ignored; it is not queued.
- Operand changes after acceptance have no effect.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, ready=1, done=0, ALUResult=0, Zero=1, counter=0.
  - Reset takes priority over every other event, including mid-MUL/DIV. An aborted operation never raises done.
- Latency, measured from the accepting edge E0:
  - Single-cycle ops and divide-by-zero: done=1 and result valid immediately after E0.
  - MUL/MULHU/DIVU/REMU: done=1 after edge E0+WIDTH. ready stays low from E0 until that same edge.
- done is high for exactly one cycle per completion.
- ready is high during the done cycle, so back-to-back requests have no bubble. A start asserted in the done cycle is accepted.
- Throughput:
  - single-cycle ops: 1 per clock;
  - multi-cycle ops: 1 per WIDTH clocks.
- ALUResult changes only on completion or reset.

## Test plan
- Reset: hold rst_n=0 for 2 cycles during an active MUL. Required: ready=1, done=0, ALUResult=0, no done pulse afterwards.
- Single-cycle ops, back-to-back, WIDTH=32: SUB 5−7, then SLT 0xFFFFFFFF vs 1, then SRA 0x80000000 by 4. Required results 0xFFFFFFFE, 1, 0xF8000000 on consecutive done pulses, one clock each.
- Multiply, WIDTH=32: MUL 0x0001_0000 × 0x0001_0000 → 0. MULHU of the same → 0x00000001. done exactly 32 cycles after acceptance; ready=0 in between.
- Divide: DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF. Each completes in 32 cycles.
- Divide by zero: DIVU 42/0 → 0xFFFFFFFF and REMU 42/0 → 42. Each completes 1 cycle after acceptance.
- Handshake: pulse start with new operands while busy in DIV. Required: ignored, result unchanged. Then start=1 during the done cycle with an ADD 3+4. Required: accepted, 7 valid on the next clock.
